// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store
//  Ports: clk, reset (sync, active-high)
//   IF side : if_req, if_addr -> if_rdata, if_ready (1-cycle pulse), stall_if
//   DM side : dm_read, dm_write, dm_addr, dm_wdata -> dm_rdata, dm_ready (1-cycle pulse), stall_dm
//   Memory  : mem_en, mem_we, mem_addr, mem_wdata (registered) <- mem_rdata
//  Optional: define ROUND_ROBIN_EN to alternate grants on IF/DM conflicts (default: DM wins).
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic              r_mem_en, w_mem_en, r_mem_we, w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata, r_if_rdata, w_if_rdata, r_dm_rdata, w_dm_rdata;
  logic              r_if_ready, w_if_ready, r_dm_ready, w_dm_ready;
  logic              w_dm_req, w_grant, w_pick_dm;
  assign w_dm_req = dm_read | dm_write;
  // the ready cycle belongs to the requester finishing, so no new sampling then
  assign w_grant  = ~r_if_ready & ~r_dm_ready & (w_dm_req | if_req);
`ifdef ROUND_ROBIN_EN
  logic r_last_dm, w_last_dm;
  assign w_pick_dm = w_dm_req & (~if_req | ~r_last_dm);
`else
  assign w_pick_dm = w_dm_req;
`endif
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_mem_en    = r_mem_en;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_if_rdata  = r_if_rdata;
    w_dm_rdata  = r_dm_rdata;
    w_if_ready  = 1'b0;
    w_dm_ready  = 1'b0;
`ifdef ROUND_ROBIN_EN
    w_last_dm   = r_last_dm;
`endif
    if (r_state == IDLE) begin
      if (w_grant) begin
        w_state     = w_pick_dm ? BUSY_DM : BUSY_IF;
        w_mem_en    = 1'b1;
        w_mem_we    = w_pick_dm & dm_write;
        w_mem_addr  = w_pick_dm ? dm_addr : if_addr;
        w_mem_wdata = w_pick_dm ? dm_wdata : r_mem_wdata;
        w_cnt       = CW'(MEM_LATENCY - 1);
`ifdef ROUND_ROBIN_EN
        w_last_dm   = w_pick_dm;
`endif
      end
    end else if (r_cnt != '0) begin
      w_cnt = r_cnt - CW'(1);
    end else begin
      w_state    = IDLE;
      w_mem_en   = 1'b0;
      w_mem_we   = 1'b0;
      w_if_ready = r_state == BUSY_IF;
      w_dm_ready = r_state == BUSY_DM;
      w_if_rdata = r_state == BUSY_IF ? mem_rdata : r_if_rdata;
      // stores leave the last load data in place
      w_dm_rdata = (r_state == BUSY_DM && !r_mem_we) ? mem_rdata : r_dm_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_last_dm   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_if_rdata  <= w_if_rdata;
      r_dm_rdata  <= w_dm_rdata;
      r_if_ready  <= w_if_ready;
      r_dm_ready  <= w_dm_ready;
`ifdef ROUND_ROBIN_EN
      r_last_dm   <= w_last_dm;
`endif
    end
  end
  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ready  = r_dm_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall_if  = if_req & ~r_if_ready;
  assign stall_dm  = w_dm_req & ~r_dm_ready;
endmodule
